cpu_clk_gen: RTL and testbench

Programmable CPU clock generator with run, halt and single-step control. It divides the board clock into a 50 % duty `clk_out` whose half-period is selectable at runtime, and provides one-cycle edge ticks for logic that stays on `clk`. It sits between the board clock and the single-cycle CPU core. The debug UART/switch logic drives run, step and divisor reload.

---
 rtl/cpu_clk_gen.sv | 101 ++++++++++
 tb/tb_cpu_clk_gen.sv | 119 +++++++++++
 2 files changed

// File: rtl/cpu_clk_gen.sv
// cpu_clk_gen: run/halt/step CPU clock divider; CPU_CLK_STEP_EN enables single-step.
module cpu_clk_gen #(
    parameter int CNT_W       = 16,
    parameter int DEFAULT_DIV = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             step,
    input  logic [CNT_W-1:0] div_in,
    input  logic             div_load,
    output logic             div_ack,
    output logic             clk_out,
    output logic             rise_tick,
    output logic             fall_tick,
    output logic             halted
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
`ifdef CPU_CLK_STEP_EN
    localparam logic [1:0] STEP = 2'd2;
`else
    logic step_unused;
    assign step_unused = step;
`endif
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] hp_q, hp_d;
    logic [CNT_W-1:0] pend_val_q, pend_val_d;
    logic             pend_vld_q, pend_vld_d;
    logic             clk_out_q, clk_out_d;
    logic             rise_tick_q, rise_tick_d;
    logic             fall_tick_q, fall_tick_d;
    logic             div_ack_q, div_ack_d;
    logic             halted_q, halted_d;
    logic             active, bound, fall_b, apply;

    // Next-state: STEP counts exactly like RUN, so both only leave on a fall boundary.
    always_comb begin
        active      = state_q != IDLE;
        bound       = active && cnt_q == hp_q;
        fall_b      = bound && clk_out_q;
        apply       = pend_vld_q && (!active || fall_b);
        state_d     = state_q;
        cnt_d       = '0;
        clk_out_d   = 1'b0;
        hp_d        = apply ? pend_val_q : hp_q;
        pend_val_d  = div_load ? div_in : pend_val_q;
        pend_vld_d  = div_load || (pend_vld_q && !apply);
        div_ack_d   = apply;
        rise_tick_d = bound && !clk_out_q;
        fall_tick_d = fall_b;
        halted_d    = state_q == IDLE;
        if (!active) begin
            if (run)
                state_d = RUN;
`ifdef CPU_CLK_STEP_EN
            else if (step)
                state_d = STEP;
`endif
        end else begin
            cnt_d     = bound ? '0 : cnt_q + CNT_W'(1);
            clk_out_d = bound ? !clk_out_q : clk_out_q;
            if (fall_b)
                state_d = run ? RUN : IDLE;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            hp_q        <= CNT_W'(DEFAULT_DIV);
            pend_val_q  <= '0;
            pend_vld_q  <= 1'b0;
            clk_out_q   <= 1'b0;
            rise_tick_q <= 1'b0;
            fall_tick_q <= 1'b0;
            div_ack_q   <= 1'b0;
            halted_q    <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hp_q        <= hp_d;
            pend_val_q  <= pend_val_d;
            pend_vld_q  <= pend_vld_d;
            clk_out_q   <= clk_out_d;
            rise_tick_q <= rise_tick_d;
            fall_tick_q <= fall_tick_d;
            div_ack_q   <= div_ack_d;
            halted_q    <= halted_d;
        end
    end

    assign clk_out   = clk_out_q;
    assign rise_tick = rise_tick_q;
    assign fall_tick = fall_tick_q;
    assign div_ack   = div_ack_q;
    assign halted    = halted_q;
endmodule

// File: tb/tb_cpu_clk_gen.sv
// tb_cpu_clk_gen: vector table of per-edge expectations derived from period arithmetic.
module tb_cpu_clk_gen;
    typedef struct {
        string       nm;
        int          k;
        logic        rst, run, step, ld;
        logic [15:0] din;
        logic [4:0]  exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1, run = 1'b0, step = 1'b0, div_load = 1'b0;
    logic [15:0] div_in = '0;
    logic        div_ack, clk_out, rise_tick, fall_tick, halted;
    vec_t        tbl[$];
    vec_t        sb[$];
    int          nvec = 0, nbad = 0;

    cpu_clk_gen dut (
        .clk(clk), .rst(rst), .run(run), .step(step),
        .div_in(div_in), .div_load(div_load), .div_ack(div_ack),
        .clk_out(clk_out), .rise_tick(rise_tick), .fall_tick(fall_tick), .halted(halted)
    );

    always #5 clk = ~clk;

    function automatic void push_v(string nm, int k, logic r, logic rn, logic st, logic ld,
                                   logic [15:0] din, logic [4:0] exp);
        vec_t v;
        v.nm = nm; v.k = k; v.rst = r; v.run = rn; v.step = st; v.ld = ld; v.din = din; v.exp = exp;
        tbl.push_back(v);
    endfunction

    // Edge k counts from the edge where run/step is first sampled. Half period h+1 cycles;
    // after edge ksw the period restarts with hpb. Stops at the first low-going edge with run low.
    function automatic void push_run(string nm, int hpa, int ksw, int hpb, int kld, int din,
                                     int nrun, int ntot, bit stp);
        int h, b, kf;
        bit e, hi, s;
        kf = -1;
        for (int k = 0; k < ntot; k++) begin
            h  = (k <= ksw) ? hpa : hpb;
            b  = (k <= ksw) ? k : k - ksw;
            e  = b > 0 && b % (h + 1) == 0;
            hi = (b / (h + 1)) % 2 == 1;
            s  = kf >= 0 && k > kf;
            if (kf < 0 && k >= nrun && e && !hi) kf = k;
            push_v(nm, k, 1'b0, k < nrun, stp && (k == 0 || k == 2), k == kld, 16'(din),
                   {!s && hi, !s && e && hi, !s && e && !hi, k == ksw && kld >= 0, k == 0 || s});
        end
    endfunction

    initial begin
        vec_t v, x;
        logic [4:0] got;
        int n;
        push_v("reset", 0, 1, 0, 0, 0, 0, 5'b00001);
        push_v("reset", 1, 1, 1, 1, 1, 5, 5'b00001);
        push_run("run_hp10", 10, 1000, 10, -1, 0, 57, 71, 0);
        push_v("load0", 0, 0, 0, 0, 1, 0, 5'b00001);
        push_v("load0", 1, 0, 0, 0, 0, 0, 5'b00011);
        push_run("run_hp0", 0, 1000, 0, -1, 0, 8, 12, 0);
        push_v("load10", 0, 0, 0, 0, 1, 10, 5'b00001);
        push_v("load10", 1, 0, 0, 0, 0, 10, 5'b00011);
        push_run("reload3", 10, 22, 3, 14, 3, 40, 49, 0);
        push_run("pre_rst", 3, 1000, 3, 5, 9, 100, 6, 0);
        push_v("mid_rst", 0, 1, 1, 0, 0, 9, 5'b00001);
        push_run("post_rst", 10, 1000, 10, -1, 9, 20, 26, 0);
        push_v("load2", 0, 0, 0, 0, 1, 2, 5'b00001);
        push_v("load2", 1, 0, 0, 0, 0, 2, 5'b00011);
`ifdef CPU_CLK_STEP_EN
        push_run("step", 2, 1000, 2, -1, 2, 0, 10, 1);
`else
        for (int k = 0; k < 10; k++)
            push_v("step_off", k, 0, 0, k == 0 || k == 2, 0, 2, 5'b00001);
`endif
        foreach (tbl[i]) begin
            v = tbl[i];
            @(negedge clk);
            rst = v.rst; run = v.run; step = v.step; div_load = v.ld; div_in = v.din;
            sb.push_back(v);
            @(posedge clk);
            #1;
            x   = sb.pop_front();
            got = {clk_out, rise_tick, fall_tick, div_ack, halted};
            nvec++;
            if (got !== x.exp) begin
                nbad++;
                $display("FAIL %s[%0d]: clk_out/rise/fall/ack/halted got %b want %b",
                         x.nm, x.k, got, x.exp);
            end
        end
        @(negedge clk);
        rst = 1'b1; run = 1'b0; step = 1'b0; div_load = 1'b0;
        @(posedge clk);
        #1;
        nvec++;
        if ({clk_out, rise_tick, fall_tick, div_ack, halted} !== 5'b00001) begin
            nbad++;
            $display("FAIL reset_state: got %b want 00001",
                     {clk_out, rise_tick, fall_tick, div_ack, halted});
        end
        @(negedge clk);
        rst = 1'b0; run = 1'b1;
        n = 0;
        while (clk_out !== 1'b1 && n < 30) begin
            @(posedge clk);
            #1;
            n++;
        end
        nvec++;
        if (clk_out !== 1'b1) begin
            nbad++;
            $display("FAIL wait_rise: clk_out never rose within %0d cycles", n);
        end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end
endmodule
